time_set_ctrl: RTL and testbench
================================

Name: time_set_ctrl

Overview:
- Button-driven setting controller that sequences the time-calculation datapath.
- Owns the user-facing view/edit state machine and holds editable copies of time, date and alarm.
- Drives the datapath's MODE, MODE_STATE and SETTING controls.
- Sits between the debounced button block and the time-calculation block; its OUT_* buses feed the datapath's IN_* load inputs.

Parameters:
- TIMEOUT_CYCLES, 1000: idle cycles in an edit state before the edit is aborted.
- BLINK_CYCLES, 50: half-period of the edit-field blink, in cycles.

Ports:
- CLK  in  1  clock
- RESETN  in  1  reset; synchronous, active-low
- BTN_MODE  in  1  single-cycle pulse; toggles clock/alarm view, or aborts an edit
- BTN_OK  in  1  single-cycle pulse; enters edit, or commits an edit
- BTN_NEXT  in  1  single-cycle pulse; advances the edit field
- BTN_UP  in  1  single-cycle pulse; increments the current field
- BTN_DOWN  in  1  single-cycle pulse; decrements the current field
- CUR_TIME  in  18  live time {MERIDIAN, HOUR[4:0], MIN[5:0], SEC[5:0]}
- CUR_DATE  in  16  live date {YEAR[6:0], MONTH[3:0], DAY[4:0]}
- CUR_ALARM  in  17  live alarm {HOUR, MIN, SEC}
- MODE  out  1  1 for exactly one cycle to load OUT_* into the datapath
- MODE_STATE  out  1  0 = time/date target, 1 = alarm target
- SETTING  out  1  1 while editing; freezes the datapath tick counter
- OUT_TIME  out  18  edited time
- OUT_DATE  out  16  edited date
- OUT_ALARM  out  17  edited alarm
- FIELD  out  3  index of the field being edited
- BLINK  out  1  display blank phase for FIELD

Behaviour:
- All outputs are registered. A button pulse sampled at edge N takes effect at edge N+1.
- Reset values:
  - State IDLE.
  - MODE = 0, MODE_STATE = 0, SETTING = 0, FIELD = 0, BLINK = 0.
  - OUT_TIME = 0, OUT_DATE = {0,1,1}, OUT_ALARM = 0.
  - Timeout and blink counters = 0.
- Button priority when several pulses arrive in one cycle: OK > MODE > NEXT > UP > DOWN. Only the highest-priority pulse acts.
- States and transitions:
  - IDLE: MODE → VIEW_ALARM. OK → EDIT_TIME, snapshotting CUR_TIME/CUR_DATE into the OUT_* edit registers.
  - VIEW_ALARM: MODE → IDLE. OK → EDIT_ALARM, snapshotting CUR_ALARM.
  - EDIT_TIME: FIELD order 0 HOUR, 1 MIN, 2 SEC, 3 YEAR, 4 MONTH, 5 DAY; NEXT wraps 5 → 0.
  - EDIT_ALARM: FIELD order 0 HOUR, 1 MIN, 2 SEC; NEXT wraps 2 → 0.
  - In either EDIT state:
    - OK → COMMIT.
    - MODE → abort: return to IDLE (from EDIT_TIME) or VIEW_ALARM (from EDIT_ALARM); edit registers are not loaded.
  - COMMIT: one cycle with MODE = 1 and SETTING = 0, then → IDLE (time target) or VIEW_ALARM (alarm target).
- Control outputs per state:
  - MODE_STATE = 1 in VIEW_ALARM, EDIT_ALARM and alarm COMMIT; 0 otherwise.
  - SETTING = 1 only in the EDIT states.
- Field ranges; UP/DOWN wrap at both ends:
  - HOUR 0..23.
  - MIN and SEC 0..59.
  - YEAR 0..99.
  - MONTH 1..12.
  - DAY 1..dim, where dim = 31/30/28/29 per month; leap year when YEAR[1:0] == 0.
- MERIDIAN is derived, not edited: MERIDIAN = (HOUR ≥ 12). It is recomputed whenever HOUR changes.
- After any YEAR or MONTH change, DAY is clamped to dim in the same cycle.
- Snapshot sanitising: out-of-range captured values are forced in range.
  - MONTH 0 or > 12 → 1.
  - DAY 0 → 1; DAY > dim → dim.
  - HOUR > 23 → 0.
  - MIN or SEC > 59 → 0.
- Timeout:
  - The counter increments every cycle in an EDIT state and clears on any button pulse.
  - When it reaches TIMEOUT_CYCLES − 1, the FSM goes to IDLE with no commit.
- BLINK:
  - Toggles every BLINK_CYCLES in EDIT states.
  - Forced to 0 and its counter cleared on any button pulse.
  - 0 outside EDIT states.
- Reset asserted mid-edit or mid-COMMIT returns everything to the reset values at that edge. A pending COMMIT is discarded (MODE stays 0).
- The CUR_* inputs are ignored except at the snapshot edge.

Test Plan:
- Reset, then idle 10 cycles → MODE = 0, SETTING = 0, MODE_STATE = 0, FIELD = 0, OUT_DATE = {0,1,1}.
- CUR_TIME = 11:59:30, OK; UP on HOUR; OK → OUT_TIME HOUR = 12 with MERIDIAN = 1; MODE high for exactly one cycle with MODE_STATE = 0; SETTING falls on the COMMIT cycle.
- Edit date YEAR = 23, MONTH = 3, DAY = 31; DOWN on MONTH → MONTH = 2, DAY = 28. Set YEAR = 24 → DAY stays 28. UP DAY → 29; UP again → 1.
- MODE, OK, set alarm MIN = 0, DOWN → MIN = 59; OK → MODE pulse with MODE_STATE = 1, then state VIEW_ALARM.
- OK, then no buttons for 1000 cycles → back to IDLE with MODE never asserted. Repeat with a NEXT press at cycle 900 → still editing at cycle 1000.
- OK+UP+NEXT pulsed in the same cycle while in EDIT_TIME → COMMIT only, field value unchanged. Assert RESETN = 0 during COMMIT → MODE = 0 at the next edge.

Source files
------------

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: button-driven view/edit FSM holding editable time, date and alarm copies for the datapath
module time_set_ctrl #(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int BLINK_CYCLES = 50
) (
   input  logic        CLK,
   input  logic        RESETN,
   input  logic        BTN_MODE,
   input  logic        BTN_OK,
   input  logic        BTN_NEXT,
   input  logic        BTN_UP,
   input  logic        BTN_DOWN,
   input  logic [17:0] CUR_TIME,
   input  logic [15:0] CUR_DATE,
   input  logic [16:0] CUR_ALARM,
   output logic        MODE,
   output logic        MODE_STATE,
   output logic        SETTING,
   output logic [17:0] OUT_TIME,
   output logic [15:0] OUT_DATE,
   output logic [16:0] OUT_ALARM,
   output logic [2:0]  FIELD,
   output logic        BLINK
);
   typedef enum logic [2:0] {IDLE, VIEW_ALARM, EDIT_TIME, EDIT_ALARM, COMMIT} state_t;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int BW = $clog2(BLINK_CYCLES + 1);
   state_t state, state_n;
   logic [4:0] btn_q;
   logic p_ok, p_mode, p_next, p_up, p_down, any_btn, timeout, edit_n, ms_n, blink_n, mer, mer_n;
   logic [2:0] field_n;
   logic [4:0] t_hour, t_hour_n, d_day, d_day_n, a_hour, a_hour_n, dim_n;
   logic [5:0] t_min, t_min_n, t_sec, t_sec_n, a_min, a_min_n, a_sec, a_sec_n;
   logic [6:0] d_year, d_year_n;
   logic [3:0] d_month, d_month_n;
   logic [TW-1:0] to_cnt, to_n;
   logic [BW-1:0] bl_cnt, bl_n;
   logic unused_mer;

   assign unused_mer = CUR_TIME[17];
   assign OUT_TIME = {mer, t_hour, t_min, t_sec};
   assign OUT_DATE = {d_year, d_month, d_day};
   assign OUT_ALARM = {a_hour, a_min, a_sec};

   function automatic logic [4:0] dim_f(input logic [6:0] y, input logic [3:0] m);
      return m == 4'd2 ? (y[1:0] == 2'd0 ? 5'd29 : 5'd28) :
             (m == 4'd4 || m == 4'd6 || m == 4'd9 || m == 4'd11) ? 5'd30 : 5'd31;
   endfunction

   function automatic logic [6:0] step(input logic [6:0] v, input logic [6:0] lo, input logic [6:0] hi, input logic up);
      return up ? (v >= hi ? lo : v + 7'd1) : (v <= lo ? hi : v - 7'd1);
   endfunction

   always_comb begin
      p_ok = btn_q[4];
      p_mode = btn_q[3] & ~btn_q[4];
      p_next = btn_q[2] & ~|btn_q[4:3];
      p_up = btn_q[1] & ~|btn_q[4:2];
      p_down = btn_q[0] & ~|btn_q[4:1];
      any_btn = |btn_q;
      timeout = to_cnt == TW'(TIMEOUT_CYCLES - 1);
      state_n = state;
      field_n = FIELD;
      t_hour_n = t_hour;
      t_min_n = t_min;
      t_sec_n = t_sec;
      d_year_n = d_year;
      d_month_n = d_month;
      d_day_n = d_day;
      a_hour_n = a_hour;
      a_min_n = a_min;
      a_sec_n = a_sec;
      case (state)
         IDLE:
            if (p_ok) begin
               state_n = EDIT_TIME;
               t_hour_n = CUR_TIME[16:12] > 5'd23 ? 5'd0 : CUR_TIME[16:12];
               t_min_n = CUR_TIME[11:6] > 6'd59 ? 6'd0 : CUR_TIME[11:6];
               t_sec_n = CUR_TIME[5:0] > 6'd59 ? 6'd0 : CUR_TIME[5:0];
               d_year_n = CUR_DATE[15:9] > 7'd99 ? 7'd0 : CUR_DATE[15:9];
               d_month_n = (CUR_DATE[8:5] == 4'd0 || CUR_DATE[8:5] > 4'd12) ? 4'd1 : CUR_DATE[8:5];
               d_day_n = CUR_DATE[4:0];
            end else if (p_mode) state_n = VIEW_ALARM;
         VIEW_ALARM:
            if (p_ok) begin
               state_n = EDIT_ALARM;
               a_hour_n = CUR_ALARM[16:12] > 5'd23 ? 5'd0 : CUR_ALARM[16:12];
               a_min_n = CUR_ALARM[11:6] > 6'd59 ? 6'd0 : CUR_ALARM[11:6];
               a_sec_n = CUR_ALARM[5:0] > 6'd59 ? 6'd0 : CUR_ALARM[5:0];
            end else if (p_mode) state_n = IDLE;
         EDIT_TIME, EDIT_ALARM:
            if (p_ok) state_n = COMMIT;
            else if (p_mode) state_n = state == EDIT_TIME ? IDLE : VIEW_ALARM;
            else if (p_next) field_n = (state == EDIT_TIME ? FIELD == 3'd5 : FIELD == 3'd2) ? 3'd0 : FIELD + 3'd1;
            else if (p_up | p_down) begin
               if (state == EDIT_ALARM) begin
                  a_hour_n = FIELD == 3'd0 ? 5'(step(7'(a_hour), 7'd0, 7'd23, p_up)) : a_hour;
                  a_min_n = FIELD == 3'd1 ? 6'(step(7'(a_min), 7'd0, 7'd59, p_up)) : a_min;
                  a_sec_n = FIELD == 3'd2 ? 6'(step(7'(a_sec), 7'd0, 7'd59, p_up)) : a_sec;
               end else begin
                  t_hour_n = FIELD == 3'd0 ? 5'(step(7'(t_hour), 7'd0, 7'd23, p_up)) : t_hour;
                  t_min_n = FIELD == 3'd1 ? 6'(step(7'(t_min), 7'd0, 7'd59, p_up)) : t_min;
                  t_sec_n = FIELD == 3'd2 ? 6'(step(7'(t_sec), 7'd0, 7'd59, p_up)) : t_sec;
                  d_year_n = FIELD == 3'd3 ? step(d_year, 7'd0, 7'd99, p_up) : d_year;
                  d_month_n = FIELD == 3'd4 ? 4'(step(7'(d_month), 7'd1, 7'd12, p_up)) : d_month;
                  d_day_n = FIELD == 3'd5 ? 5'(step(7'(d_day), 7'd1, 7'(dim_f(d_year, d_month)), p_up)) : d_day;
               end
            end else if (timeout) state_n = IDLE;
         COMMIT: state_n = MODE_STATE ? VIEW_ALARM : IDLE;
         default: state_n = IDLE;
      endcase
      // day follows year/month changes and snapshot sanitising in the same cycle
      dim_n = dim_f(d_year_n, d_month_n);
      d_day_n = d_day_n > dim_n ? dim_n : (d_day_n == 5'd0 ? 5'd1 : d_day_n);
      mer_n = t_hour_n >= 5'd12;
      edit_n = state_n == EDIT_TIME || state_n == EDIT_ALARM;
      field_n = edit_n ? field_n : 3'd0;
      to_n = edit_n && !any_btn ? to_cnt + TW'(1) : '0;
      bl_n = edit_n && !any_btn && bl_cnt != BW'(BLINK_CYCLES - 1) ? bl_cnt + BW'(1) : '0;
      blink_n = edit_n && !any_btn && (bl_cnt == BW'(BLINK_CYCLES - 1) ? ~BLINK : BLINK);
      ms_n = state_n == VIEW_ALARM || state_n == EDIT_ALARM || (state_n == COMMIT && state == EDIT_ALARM);
   end

   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         state <= IDLE;
         btn_q <= '0;
         MODE <= 1'b0;
         MODE_STATE <= 1'b0;
         SETTING <= 1'b0;
         FIELD <= 3'd0;
         BLINK <= 1'b0;
         to_cnt <= '0;
         bl_cnt <= '0;
         mer <= 1'b0;
         t_hour <= 5'd0;
         t_min <= 6'd0;
         t_sec <= 6'd0;
         d_year <= 7'd0;
         d_month <= 4'd1;
         d_day <= 5'd1;
         a_hour <= 5'd0;
         a_min <= 6'd0;
         a_sec <= 6'd0;
      end else begin
         state <= state_n;
         btn_q <= {BTN_OK, BTN_MODE, BTN_NEXT, BTN_UP, BTN_DOWN};
         MODE <= state_n == COMMIT;
         MODE_STATE <= ms_n;
         SETTING <= edit_n;
         FIELD <= field_n;
         BLINK <= blink_n;
         to_cnt <= to_n;
         bl_cnt <= bl_n;
         mer <= mer_n;
         t_hour <= t_hour_n;
         t_min <= t_min_n;
         t_sec <= t_sec_n;
         d_year <= d_year_n;
         d_month <= d_month_n;
         d_day <= d_day_n;
         a_hour <= a_hour_n;
         a_min <= a_min_n;
         a_sec <= a_sec_n;
      end
   end
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed stimulus with a commit scoreboard checked on every MODE pulse
module tb_time_set_ctrl;
   logic CLK = 1'b0, RESETN = 1'b0;
   logic BTN_MODE = 1'b0, BTN_OK = 1'b0, BTN_NEXT = 1'b0, BTN_UP = 1'b0, BTN_DOWN = 1'b0;
   logic [17:0] CUR_TIME;
   logic [15:0] CUR_DATE;
   logic [16:0] CUR_ALARM;
   logic MODE, MODE_STATE, SETTING, BLINK;
   logic [17:0] OUT_TIME;
   logic [15:0] OUT_DATE;
   logic [16:0] OUT_ALARM;
   logic [2:0] FIELD;

   typedef struct packed {
      logic ms;
      logic setting;
      logic [17:0] t;
      logic [15:0] d;
      logic [16:0] a;
   } rec_t;

   localparam logic [4:0] OK = 5'b10000, MD = 5'b01000, NX = 5'b00100, UP = 5'b00010, DN = 5'b00001;

   rec_t exp_q[$];
   rec_t got_r, exp_r;
   int checks = 0, errors = 0;
   logic prev_mode = 1'b0;

   time_set_ctrl dut (
      .CLK(CLK), .RESETN(RESETN), .BTN_MODE(BTN_MODE), .BTN_OK(BTN_OK), .BTN_NEXT(BTN_NEXT),
      .BTN_UP(BTN_UP), .BTN_DOWN(BTN_DOWN), .CUR_TIME(CUR_TIME), .CUR_DATE(CUR_DATE),
      .CUR_ALARM(CUR_ALARM), .MODE(MODE), .MODE_STATE(MODE_STATE), .SETTING(SETTING),
      .OUT_TIME(OUT_TIME), .OUT_DATE(OUT_DATE), .OUT_ALARM(OUT_ALARM), .FIELD(FIELD), .BLINK(BLINK)
   );

   always #5 CLK = ~CLK;

   function automatic logic [17:0] tm(input int m, input int h, input int mi, input int s);
      return {1'(m), 5'(h), 6'(mi), 6'(s)};
   endfunction

   function automatic logic [15:0] dt(input int y, input int mo, input int d);
      return {7'(y), 4'(mo), 5'(d)};
   endfunction

   function automatic logic [16:0] al(input int h, input int mi, input int s);
      return {5'(h), 6'(mi), 6'(s)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   // button is captured at the first edge and acted on at the second
   task automatic press(input logic [4:0] b);
      {BTN_OK, BTN_MODE, BTN_NEXT, BTN_UP, BTN_DOWN} = b;
      @(posedge CLK);
      #1;
      {BTN_OK, BTN_MODE, BTN_NEXT, BTN_UP, BTN_DOWN} = 5'b0;
      @(posedge CLK);
      #1;
   endtask

   always @(negedge CLK) begin
      if (RESETN && MODE) begin
         got_r = {MODE_STATE, SETTING, OUT_TIME, OUT_DATE, OUT_ALARM};
         checks++;
         if (prev_mode) begin
            errors++;
            $display("FAIL mode_width: MODE high on consecutive cycles");
         end
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_commit: got %h expected no MODE pulse", got_r);
         end else begin
            exp_r = exp_q.pop_front();
            if (got_r !== exp_r) begin
               errors++;
               $display("FAIL commit_record: got %h expected %h", got_r, exp_r);
            end
         end
      end
      prev_mode <= MODE;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      CUR_TIME = tm(0, 11, 59, 30);
      CUR_DATE = dt(23, 3, 31);
      CUR_ALARM = al(7, 0, 15);
      tick(3);
      RESETN = 1'b1;
      tick(10);
      chk("rst MODE", 32'(MODE), 32'd0);
      chk("rst SETTING", 32'(SETTING), 32'd0);
      chk("rst MODE_STATE", 32'(MODE_STATE), 32'd0);
      chk("rst FIELD", 32'(FIELD), 32'd0);
      chk("rst BLINK", 32'(BLINK), 32'd0);
      chk("rst OUT_DATE", 32'(OUT_DATE), 32'(dt(0, 1, 1)));
      chk("rst OUT_TIME", 32'(OUT_TIME), 32'd0);
      chk("rst OUT_ALARM", 32'(OUT_ALARM), 32'd0);

      press(OK);
      chk("edit SETTING", 32'(SETTING), 32'd1);
      chk("snap time", 32'(OUT_TIME), 32'(tm(0, 11, 59, 30)));
      chk("snap FIELD", 32'(FIELD), 32'd0);
      press(UP);
      chk("hour 11->12", 32'(OUT_TIME), 32'(tm(1, 12, 59, 30)));
      exp_q.push_back({1'b0, 1'b0, tm(1, 12, 59, 30), dt(23, 3, 31), al(0, 0, 0)});
      press(OK);
      chk("commit MODE", 32'(MODE), 32'd1);
      chk("commit SETTING", 32'(SETTING), 32'd0);
      chk("commit MODE_STATE", 32'(MODE_STATE), 32'd0);
      tick(1);
      chk("post commit MODE", 32'(MODE), 32'd0);
      chk("post commit MODE_STATE", 32'(MODE_STATE), 32'd0);

      press(OK);
      repeat (4) press(NX);
      chk("field month", 32'(FIELD), 32'd4);
      press(DN);
      chk("month down clamp", 32'(OUT_DATE), 32'(dt(23, 2, 28)));
      repeat (5) press(NX);
      chk("field wrap to year", 32'(FIELD), 32'd3);
      press(UP);
      chk("leap year day", 32'(OUT_DATE), 32'(dt(24, 2, 28)));
      repeat (2) press(NX);
      press(UP);
      chk("day 29", 32'(OUT_DATE), 32'(dt(24, 2, 29)));
      press(UP);
      chk("day wrap", 32'(OUT_DATE), 32'(dt(24, 2, 1)));
      press(MD);
      chk("abort SETTING", 32'(SETTING), 32'd0);
      chk("abort MODE_STATE", 32'(MODE_STATE), 32'd0);

      press(MD);
      chk("view alarm MODE_STATE", 32'(MODE_STATE), 32'd1);
      press(OK);
      chk("alarm edit SETTING", 32'(SETTING), 32'd1);
      chk("alarm snap", 32'(OUT_ALARM), 32'(al(7, 0, 15)));
      press(NX);
      press(DN);
      chk("alarm min wrap", 32'(OUT_ALARM), 32'(al(7, 59, 15)));
      repeat (2) press(NX);
      chk("alarm field wrap", 32'(FIELD), 32'd0);
      exp_q.push_back({1'b1, 1'b0, tm(0, 11, 59, 30), dt(24, 2, 1), al(7, 59, 15)});
      press(OK);
      chk("alarm commit MODE", 32'(MODE), 32'd1);
      chk("alarm commit MODE_STATE", 32'(MODE_STATE), 32'd1);
      tick(1);
      chk("back to view MODE_STATE", 32'(MODE_STATE), 32'd1);
      chk("back to view SETTING", 32'(SETTING), 32'd0);

      press(MD);
      press(OK);
      tick(49);
      chk("blink low", 32'(BLINK), 32'd0);
      tick(1);
      chk("blink high", 32'(BLINK), 32'd1);
      tick(50);
      chk("blink low again", 32'(BLINK), 32'd0);
      tick(899);
      chk("pre timeout SETTING", 32'(SETTING), 32'd1);
      tick(1);
      chk("timeout SETTING", 32'(SETTING), 32'd0);
      chk("timeout MODE_STATE", 32'(MODE_STATE), 32'd0);

      press(OK);
      tick(898);
      press(NX);
      chk("late next FIELD", 32'(FIELD), 32'd1);
      tick(100);
      chk("timeout restarted", 32'(SETTING), 32'd1);
      press(MD);
      chk("abort after late next", 32'(SETTING), 32'd0);

      press(OK);
      tick(59);
      chk("blink phase", 32'(BLINK), 32'd1);
      press(NX);
      chk("blink cleared", 32'(BLINK), 32'd0);
      tick(49);
      chk("blink restarted low", 32'(BLINK), 32'd0);
      tick(1);
      chk("blink restarted high", 32'(BLINK), 32'd1);
      exp_q.push_back({1'b0, 1'b0, tm(0, 11, 59, 30), dt(23, 3, 31), al(7, 59, 15)});
      press(OK | UP | NX);
      chk("priority commit MODE", 32'(MODE), 32'd1);
      chk("priority time kept", 32'(OUT_TIME), 32'(tm(0, 11, 59, 30)));
      tick(1);
      chk("priority post MODE", 32'(MODE), 32'd0);

      press(OK);
      press(OK);
      chk("pre reset MODE", 32'(MODE), 32'd1);
      RESETN = 1'b0;
      tick(1);
      chk("reset in commit MODE", 32'(MODE), 32'd0);
      chk("reset in commit OUT_TIME", 32'(OUT_TIME), 32'd0);
      chk("reset in commit OUT_DATE", 32'(OUT_DATE), 32'(dt(0, 1, 1)));
      chk("reset in commit OUT_ALARM", 32'(OUT_ALARM), 32'd0);
      chk("reset in commit SETTING", 32'(SETTING), 32'd0);
      RESETN = 1'b1;
      tick(2);

      press(OK);
      BTN_OK = 1'b1;
      tick(1);
      BTN_OK = 1'b0;
      RESETN = 1'b0;
      tick(1);
      chk("pending commit dropped", 32'(MODE), 32'd0);
      RESETN = 1'b1;
      tick(3);
      chk("no late commit", 32'(MODE), 32'd0);
      chk("idle after reset", 32'(SETTING), 32'd0);

      tick(2);
      chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
